tmds_channel_receiver: RTL and testbench

//  Receive side of one TMDS lane: deserialises the sampled serial stream, finds 10-bit word alignment from

---
 rtl/tmds_pkg.sv | 35 +++
 rtl/tmds_channel_receiver_decoder.sv | 31 +++
 rtl/tmds_channel_receiver.sv | 155 +++++++++++++++
 tb/tb_tmds_channel_receiver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, token lookup and receiver FSM states.
package tmds_pkg;

   localparam int unsigned WORD_W     = 10;
   localparam int unsigned PIX_W      = 8;
   localparam int unsigned CTRL_W     = 2;
   localparam int unsigned PHASE_W    = 4;
   localparam int unsigned PHASE_LAST = 9;

   // Control tokens, also used by the transmit encoder
   localparam logic [WORD_W-1:0] TOKEN_C00 = 10'h354;
   localparam logic [WORD_W-1:0] TOKEN_C01 = 10'h0AB;
   localparam logic [WORD_W-1:0] TOKEN_C10 = 10'h154;
   localparam logic [WORD_W-1:0] TOKEN_C11 = 10'h2AB;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   // Returns {is_token, ctrl[1:0]}; ctrl is 0 for non-token words
   function automatic logic [2:0] token_lookup(input logic [WORD_W-1:0] raw);
      logic [2:0] res;
      case (raw)
         TOKEN_C00: res = 3'b100;
         TOKEN_C01: res = 3'b101;
         TOKEN_C10: res = 3'b110;
         TOKEN_C11: res = 3'b111;
         default:   res = 3'b000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/tmds_channel_receiver_decoder.sv
// Combinational TMDS word decoder: 10-bit symbol to token flag, control pair and pixel byte.
module tmds_word_decoder
   import tmds_pkg::*;
(
   input  logic [9:0] i_raw,
   output logic       o_is_token_c,
   output logic [1:0] o_ctrl_c,
   output logic [7:0] o_data_c
);

   logic [2:0] w_tok;
   logic [7:0] w_d;

   // Control token recognition
   always_comb begin
      w_tok        = token_lookup(i_raw);
      o_is_token_c = w_tok[2];
      o_ctrl_c     = w_tok[1:0];
   end

   // Undo optional inversion (bit 9), then undo the XOR/XNOR chain (bit 8 selects)
   always_comb begin
      w_d         = i_raw[9] ? ~i_raw[7:0] : i_raw[7:0];
      o_data_c    = '0;
      o_data_c[0] = w_d[0];
      for (int i = 1; i < 8; i++) begin
         o_data_c[i] = i_raw[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
      end
   end

endmodule

// File: rtl/tmds_channel_receiver.sv
// One TMDS lane receiver: deserialise, align on control tokens, decode words.
module tmds_channel_receiver
   import tmds_pkg::*;
#(
   parameter int unsigned LOCK_TOKENS  = 8,
   parameter int unsigned MAX_DATA_RUN = 1024
)(
   input  logic       clk_high,
   input  logic       reset,
   input  logic       serial_in,
   output logic       locked,
   output logic       word_valid,
   output logic       de,
   output logic [1:0] ctrl,
   output logic [7:0] pix_data,
   output logic [9:0] raw_word
);

   localparam int unsigned TOK_W  = $clog2(LOCK_TOKENS + 1);
   localparam int unsigned RUN_W  = $clog2(MAX_DATA_RUN + 1);
   localparam int unsigned TOK_CW = TOK_W + 1;
   localparam int unsigned RUN_CW = RUN_W + 1;

   logic [WORD_W-1:0]  r_sr;
   logic [PHASE_W-1:0] r_phase;
   logic [TOK_W-1:0]   r_tok_cnt;
   logic [RUN_W-1:0]   r_run_cnt;
   state_e             r_state;
   state_e             w_state_nxt;

   logic [WORD_W-1:0]  w_cand;
   logic               w_is_token;
   logic [CTRL_W-1:0]  w_tok_ctrl;
   logic [PIX_W-1:0]   w_pix;
   logic               w_boundary;
   logic [TOK_CW-1:0]  w_tok_inc;
   logic [RUN_CW-1:0]  w_run_inc;
   logic               w_tok_done;
   logic               w_run_done;

   logic               w_locked_nxt;
   logic               w_valid_nxt;
   logic               w_de_nxt;
   logic [CTRL_W-1:0]  w_ctrl_nxt;
   logic [PIX_W-1:0]   w_pix_nxt;
   logic [WORD_W-1:0]  w_raw_nxt;

   assign w_cand     = {serial_in, r_sr[9:1]};
   assign w_boundary = (r_phase == PHASE_W'(PHASE_LAST));
   assign w_tok_inc  = {1'b0, r_tok_cnt} + TOK_CW'(1);
   assign w_run_inc  = {1'b0, r_run_cnt} + RUN_CW'(1);
   assign w_tok_done = (w_tok_inc >= TOK_CW'(LOCK_TOKENS));
   assign w_run_done = (w_run_inc >= RUN_CW'(MAX_DATA_RUN));

   tmds_word_decoder u_dec (
      .i_raw        (w_cand),
      .o_is_token_c (w_is_token),
      .o_ctrl_c     (w_tok_ctrl),
      .o_data_c     (w_pix)
   );

   // FSM state register
   always_ff @(posedge clk_high) begin
      if (!reset) r_state <= ST_HUNT;
      else        r_state <= w_state_nxt;
   end

   // FSM next state: hunt any token, verify alignment, hold lock until a long data run
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_HUNT: begin
            if (w_is_token) w_state_nxt = ST_VERIFY;
         end
         ST_VERIFY: begin
            if (w_boundary) begin
               if (!w_is_token)     w_state_nxt = ST_HUNT;
               else if (w_tok_done) w_state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (w_boundary && !w_is_token && w_run_done) w_state_nxt = ST_HUNT;
         end
         default: w_state_nxt = ST_HUNT;
      endcase
   end

   // FSM outputs: next values of the registered word outputs
   always_comb begin
      w_locked_nxt = (w_state_nxt == ST_LOCKED);
      w_valid_nxt  = 1'b0;
      w_de_nxt     = de;
      w_ctrl_nxt   = ctrl;
      w_pix_nxt    = pix_data;
      w_raw_nxt    = raw_word;
      if ((r_state == ST_LOCKED) && w_boundary && (w_state_nxt == ST_LOCKED)) begin
         w_valid_nxt = 1'b1;
         w_raw_nxt   = w_cand;
         if (w_is_token) begin
            w_de_nxt   = 1'b0;
            w_ctrl_nxt = w_tok_ctrl;
            w_pix_nxt  = '0;
         end else begin
            w_de_nxt   = 1'b1;
            w_pix_nxt  = w_pix;
         end
      end
   end

   // Output registers
   always_ff @(posedge clk_high) begin
      if (!reset) begin
         locked     <= 1'b0;
         word_valid <= 1'b0;
         de         <= 1'b0;
         ctrl       <= '0;
         pix_data   <= '0;
         raw_word   <= '0;
      end else begin
         locked     <= w_locked_nxt;
         word_valid <= w_valid_nxt;
         de         <= w_de_nxt;
         ctrl       <= w_ctrl_nxt;
         pix_data   <= w_pix_nxt;
         raw_word   <= w_raw_nxt;
      end
   end

   // Shift register, word phase and token/run counters
   always_ff @(posedge clk_high) begin
      if (!reset) begin
         r_sr      <= '0;
         r_phase   <= '0;
         r_tok_cnt <= '0;
         r_run_cnt <= '0;
      end else begin
         r_sr <= w_cand;
         if ((r_state == ST_HUNT) && w_is_token) r_phase <= '0;
         else if (w_boundary)                    r_phase <= '0;
         else                                    r_phase <= r_phase + PHASE_W'(1);

         case (r_state)
            ST_HUNT:   r_tok_cnt <= w_is_token ? TOK_W'(1) : '0;
            ST_VERIFY: if (w_boundary) r_tok_cnt <= w_is_token ? TOK_W'(w_tok_inc) : '0;
            default:   ;
         endcase

         if (r_state != ST_LOCKED)
            r_run_cnt <= '0;
         else if (w_boundary)
            r_run_cnt <= (w_is_token || w_run_done) ? '0 : RUN_W'(w_run_inc);
      end
   end

endmodule

// File: tb/tb_tmds_channel_receiver.sv
// Directed bench for tmds_channel_receiver with a per-cycle reference model.
module tb_tmds_channel_receiver;

   localparam int LOCK_N  = 8;
   localparam int MAX_RUN = 16;
   localparam logic [9:0] TOK0 = 10'h354;

   logic       clk_high;
   logic       reset;
   logic       serial_in;
   logic       locked;
   logic       word_valid;
   logic       de;
   logic [1:0] ctrl;
   logic [7:0] pix_data;
   logic [9:0] raw_word;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int         cyc;
      logic       de;
      logic [1:0] ctrl;
      logic [7:0] pix;
      logic [9:0] raw;
   } ev_t;
   ev_t log_q[$];

   // reference model state
   int         m_mode   = 0;   // 0 searching, 1 confirming, 2 aligned
   int         m_n      = 0;
   int         m_anchor = 0;
   int         m_toks   = 0;
   int         m_run    = 0;
   logic [9:0] m_win    = '0;
   logic       e_locked = 1'b0;
   logic       e_wv     = 1'b0;
   logic       e_de     = 1'b0;
   logic [1:0] e_ctrl   = '0;
   logic [7:0] e_pix    = '0;
   logic [9:0] e_raw    = '0;

   tmds_channel_receiver #(.LOCK_TOKENS(LOCK_N), .MAX_DATA_RUN(MAX_RUN)) dut (
      .clk_high   (clk_high),
      .reset      (reset),
      .serial_in  (serial_in),
      .locked     (locked),
      .word_valid (word_valid),
      .de         (de),
      .ctrl       (ctrl),
      .pix_data   (pix_data),
      .raw_word   (raw_word)
   );

   initial begin
      clk_high = 1'b0;
      forever #5 clk_high = ~clk_high;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int m_token(input logic [9:0] w);
      case (w)
         10'h354: return 0;
         10'h0AB: return 1;
         10'h154: return 2;
         10'h2AB: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] m_decode(input logic [9:0] q);
      logic [7:0] d;
      logic [7:0] x;
      d = q[9] ? ~q[7:0] : q[7:0];
      x = d ^ {d[6:0], 1'b0};
      return q[8] ? x : (x ^ 8'hFE);
   endfunction

   // One clock of the reference: word boundaries counted from the token that started the search
   task automatic model_step(input logic rst_n, input logic b);
      int t;
      if (!rst_n) begin
         m_mode = 0; m_n = 0; m_anchor = 0; m_toks = 0; m_run = 0; m_win = '0;
         e_locked = 0; e_wv = 0; e_de = 0; e_ctrl = '0; e_pix = '0; e_raw = '0;
         return;
      end
      m_n++;
      m_win = (m_win >> 1) | (10'(b) << 9);
      t = m_token(m_win);
      e_wv = 1'b0;
      if (m_mode == 0) begin
         if (t >= 0) begin m_mode = 1; m_anchor = m_n; m_toks = 1; end
      end else if (((m_n - m_anchor) % 10) == 0) begin
         if (m_mode == 1) begin
            if (t < 0) begin
               m_mode = 0; m_toks = 0;
            end else begin
               m_toks++;
               if (m_toks == LOCK_N) begin m_mode = 2; e_locked = 1; m_run = 0; end
            end
         end else if (t >= 0) begin
            m_run = 0; e_wv = 1; e_de = 0; e_ctrl = 2'(t); e_pix = '0; e_raw = m_win;
         end else begin
            m_run++;
            if (m_run == MAX_RUN) begin
               m_mode = 0; m_run = 0; m_toks = 0; e_locked = 0;
            end else begin
               e_wv = 1; e_de = 1; e_pix = m_decode(m_win); e_raw = m_win;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk_high);
      cyc++;
      model_step(reset, serial_in);
   end

   // per-cycle comparison against the model
   initial forever begin
      @(negedge clk_high);
      chk("cycle", 32'({locked, word_valid, de, ctrl, pix_data, raw_word}),
                   32'({e_locked, e_wv, e_de, e_ctrl, e_pix, e_raw}));
   end

   // emitted word log
   initial forever begin
      @(posedge clk_high);
      #1;
      if (word_valid === 1'b1) log_q.push_back('{cyc, de, ctrl, pix_data, raw_word});
   end

   task automatic send_bit(input logic b);
      @(negedge clk_high);
      serial_in = b;
   endtask

   task automatic send_word(input logic [9:0] w);
      for (int i = 0; i < 10; i++) send_bit(w[i]);
   endtask

   task automatic after_last_bit();
      @(posedge clk_high);
      #2;
   endtask

   function automatic logic [31:0] outs();
      return 32'({locked, word_valid, de, ctrl, pix_data, raw_word});
   endfunction

   logic [7:0] t3_pix [3];
   logic [9:0] t3_raw [3];
   logic [9:0] t4_raw [3];

   initial begin
      t3_pix = '{8'h00, 8'hFE, 8'h00};
      t3_raw = '{10'h100, 10'h2FF, 10'h3FF};
      t4_raw = '{10'h0AB, 10'h154, 10'h2AB};
      reset = 1'b0;
      serial_in = 1'b0;

      // 1: reset with random serial data
      repeat (5) send_bit(1'($urandom_range(0, 1)));
      @(negedge clk_high);
      chk("reset_outputs", outs(), 32'd0);
      reset = 1'b1;
      serial_in = 1'b1;
      send_bit(1'b1);
      send_bit(1'b1);

      // 2: lock on 8 tokens, 9th token emitted
      repeat (7) send_word(TOK0);
      send_word(TOK0);
      chk("pre_lock", 32'(locked), 32'd0);
      after_last_bit();
      chk("lock_rise", 32'(locked), 32'd1);
      chk("lock_word_silent", 32'(word_valid), 32'd0);
      send_word(TOK0);
      after_last_bit();
      chk("tok9_valid", 32'(word_valid), 32'd1);
      chk("tok9_de", 32'(de), 32'd0);
      chk("tok9_ctrl", 32'(ctrl), 32'd0);
      chk("tok9_raw", 32'(raw_word), 32'h354);
      log_q.delete();

      // 3: data words
      send_word(10'h100);
      send_word(10'h2FF);
      send_word(10'h3FF);
      after_last_bit();
      chk("t3_count", 32'(log_q.size()), 32'd3);
      if (log_q.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("t3_de", 32'(log_q[i].de), 32'd1);
            chk("t3_pix", 32'(log_q[i].pix), 32'(t3_pix[i]));
            chk("t3_ctrl", 32'(log_q[i].ctrl), 32'd0);
            chk("t3_raw", 32'(log_q[i].raw), 32'(t3_raw[i]));
         end
         chk("t3_spacing_a", 32'(log_q[1].cyc - log_q[0].cyc), 32'd10);
         chk("t3_spacing_b", 32'(log_q[2].cyc - log_q[1].cyc), 32'd10);
      end
      log_q.delete();

      // 4: remaining control tokens
      send_word(10'h0AB);
      send_word(10'h154);
      send_word(10'h2AB);
      after_last_bit();
      chk("t4_count", 32'(log_q.size()), 32'd3);
      if (log_q.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("t4_de", 32'(log_q[i].de), 32'd0);
            chk("t4_ctrl", 32'(log_q[i].ctrl), 32'(i + 1));
            chk("t4_pix", 32'(log_q[i].pix), 32'd0);
            chk("t4_raw", 32'(log_q[i].raw), 32'(t4_raw[i]));
         end
      end

      // 5: reset, broken token run, then a clean lock
      @(negedge clk_high);
      reset = 1'b0;
      serial_in = 1'b0;
      @(posedge clk_high);
      #1;
      chk("t5_reset_outputs", outs(), 32'd0);
      @(negedge clk_high);
      reset = 1'b1;
      log_q.delete();
      repeat (5) send_word(TOK0);
      send_word(10'h100);
      send_word(TOK0);
      chk("t5_still_unlocked", 32'(locked), 32'd0);
      repeat (6) send_word(TOK0);
      send_word(TOK0);
      chk("t5_pre_lock", 32'(locked), 32'd0);
      after_last_bit();
      chk("t5_lock", 32'(locked), 32'd1);
      chk("t5_no_words", 32'(log_q.size()), 32'd0);

      // 6: data run limit drops lock
      log_q.delete();
      for (int k = 0; k < MAX_RUN; k++) send_word(10'(10'h100 + k));
      chk("t6_locked_before", 32'(locked), 32'd1);
      after_last_bit();
      chk("t6_lock_drop", 32'(locked), 32'd0);
      chk("t6_no_valid", 32'(word_valid), 32'd0);
      chk("t6_pulses", 32'(log_q.size()), 32'(MAX_RUN - 1));

      // relock, then a one-cycle reset mid-word
      repeat (8) send_word(TOK0);
      after_last_bit();
      chk("t6_relock", 32'(locked), 32'd1);
      send_word(10'h2FF);
      after_last_bit();
      chk("t6_word_valid", 32'(word_valid), 32'd1);
      chk("t6_word_pix", 32'(pix_data), 32'hFE);
      repeat (4) send_bit(1'b1);
      @(negedge clk_high);
      reset = 1'b0;
      @(posedge clk_high);
      #1;
      chk("t6_mid_reset", outs(), 32'd0);
      @(negedge clk_high);
      reset = 1'b1;
      repeat (25) send_bit(1'($urandom_range(0, 1)));
      @(negedge clk_high);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
